// File: rtl/rle_decompressor.sv
// Run-length decoder: expands (count, value) tokens into 512-bit beats of
// sixteen 32-bit lanes, packed lowest lane first with no gaps between tokens.
// A partial beat is emitted only when the frame's last token has been fully
// expanded; a zero-count last token flushes the pending beat, or produces an
// empty tlast beat when nothing is pending.
module rle_decompressor (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [63:0]  i_data_tdata,
    input  logic [7:0]   i_data_tkeep,
    input  logic         i_data_tlast,
    input  logic         i_data_tvalid,
    output logic         i_data_tready,
    output logic [511:0] o_data_tdata,
    output logic [63:0]  o_data_tkeep,
    output logic         o_data_tlast,
    output logic         o_data_tvalid,
    input  logic         o_data_tready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_e;

    state_e         state_q,    state_d;
    logic [31:0]    run_cnt_q,  run_cnt_d;
    logic [31:0]    run_val_q,  run_val_d;
    logic           run_last_q, run_last_d;
    logic [511:0]   acc_q,      acc_d;
    logic [63:0]    acc_keep_q, acc_keep_d;
    logic [4:0]     fill_q,     fill_d;

    // Words placed this FILL cycle: the smaller of the run remainder and free lanes.
    logic [4:0]     avail;
    logic [4:0]     take;
    logic [4:0]     fill_sum;
    logic [31:0]    run_rem;
    logic [31:0]    tok_cnt;

    // Input byte enables carry no meaning for a token.
    logic           unused_tkeep;
    assign unused_tkeep = ^i_data_tkeep;

    assign tok_cnt  = i_data_tdata[63:32];
    assign avail    = 5'd16 - fill_q;
    assign take     = (run_cnt_q < {27'd0, avail}) ? run_cnt_q[4:0] : avail;
    assign fill_sum = fill_q + take;
    assign run_rem  = run_cnt_q - {27'd0, take};

    // Handshake outputs: tready is held low while reset is asserted.
    assign i_data_tready = (state_q == IDLE) && aresetn;
    assign o_data_tvalid = (state_q == EMIT);
    assign o_data_tlast  = (state_q == EMIT) && run_last_q && (run_cnt_q == 32'd0);
    assign o_data_tdata  = acc_q;
    assign o_data_tkeep  = acc_keep_q;

    // Next-state and datapath update for the IDLE/FILL/EMIT sequencer.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        run_val_d  = run_val_q;
        run_last_d = run_last_q;
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        fill_d     = fill_q;

        unique case (state_q)
            IDLE: begin
                if (i_data_tvalid) begin
                    if (tok_cnt != 32'd0) begin
                        run_cnt_d  = tok_cnt;
                        run_val_d  = i_data_tdata[31:0];
                        run_last_d = i_data_tlast;
                        state_d    = FILL;
                    end else if (i_data_tlast) begin
                        run_cnt_d  = 32'd0;
                        run_last_d = 1'b1;
                        state_d    = EMIT;
                    end
                end
            end

            FILL: begin
                for (int k = 0; k < 16; k++) begin
                    if ((5'(k) >= fill_q) && (5'(k) < fill_sum)) begin
                        acc_d[32*k +: 32]    = run_val_q;
                        acc_keep_d[4*k +: 4] = 4'hF;
                    end
                end
                run_cnt_d = run_rem;
                fill_d    = fill_sum;
                if ((fill_sum == 5'd16) || ((run_rem == 32'd0) && run_last_q)) begin
                    state_d = EMIT;
                end else if (run_rem == 32'd0) begin
                    state_d = IDLE;
                end else begin
                    state_d = FILL;
                end
            end

            EMIT: begin
                if (o_data_tready) begin
                    fill_d     = 5'd0;
                    acc_keep_d = 64'd0;
                    if (run_cnt_q != 32'd0) begin
                        state_d = FILL;
                    end else begin
                        run_last_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            run_cnt_q  <= 32'd0;
            run_val_q  <= 32'd0;
            run_last_q <= 1'b0;
            acc_keep_q <= 64'd0;
            fill_q     <= 5'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            run_val_q  <= run_val_d;
            run_last_q <= run_last_d;
            acc_keep_q <= acc_keep_d;
            fill_q     <= fill_d;
        end
    end

    // Beat data register.
    always_ff @(posedge aclk) begin
        // NOTE: lane data is left unreset; acc_keep marks which lanes hold valid words.
        acc_q <= acc_d;
    end

endmodule
